// File: rtl/beat_pkg.sv
// beat_pkg: definitions shared by the beat recorder store path and the playback sequencer.
//   - default field widths of a beat RAM entry {dur, key}
//   - ENTRY_W, the width of one beat RAM word
//   - state encoding of the playback FSM
//   - field slice macros BEAT_KEY / BEAT_DUR for a {dur, key} word
// No ports; import with beat_pkg::*.
`ifndef BEAT_PKG_SV
`define BEAT_PKG_SV

// Key sits in the low bits and duration directly above it.
`define BEAT_KEY(word, kw)     word[(kw)-1:0]
`define BEAT_DUR(word, kw, dw) word[(kw)+(dw)-1:(kw)]

package beat_pkg;

  localparam int BEAT_KEY_W = 7;
  localparam int BEAT_DUR_W = 8;
  localparam int ENTRY_W    = BEAT_DUR_W + BEAT_KEY_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_ADDR   = S_ADDR,
    ST_WAIT   = S_WAIT,
    ST_PLAY   = S_PLAY,
    ST_FINISH = S_FINISH
  } state_t;

endpackage

`endif

// File: rtl/playback_tick_divider.sv
// playback_tick_divider: emits a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk    in  system clock, rising edge
//   resetn in  asynchronous active-low reset (count cleared to 0)
//   clr    in  reload the count; the first tick then comes TICK_DIV enabled cycles later
//   en     in  count enable
//   tick   out high for the enabled cycle that ends a TICK_DIV-cycle period
module playback_tick_divider #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // TICK_DIV=1 still needs a 1-bit counter (it just stays at zero).
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/beat_playback_sequencer.sv
// beat_playback_sequencer: replays recorded {dur, key} entries from the beat RAM in address
// order, presenting each key for dur ticks (one tick = TICK_DIV clk cycles).
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   level: play while high; low aborts to IDLE on the next edge
//   length     in   number of valid entries, sampled when playback starts
//   mem_addr   out  beat RAM read address
//   mem_rdata  in   RAM word {dur, key}, synchronous read with 1-cycle latency
//   key_out    out  key currently playing (holds between entries)
//   key_valid  out  key_out is meaningful (PLAY only)
//   busy       out  high in ADDR, WAIT and PLAY
//   done       out  one-cycle pulse when the last entry completes
//   state_dbg  out  current FSM state (beat_pkg S_* encoding)
// Build option: define PLAYBACK_LOOP_EN to restart from entry 0 after the last entry
// (done still pulses at each wrap) instead of stopping in FINISH.
// start has no handshake: it is a level, and only its rising edge (seen in IDLE) begins a pass.
module beat_playback_sequencer
  import beat_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int KEY_W    = BEAT_KEY_W,
  parameter int DUR_W    = BEAT_DUR_W,
  parameter int TICK_DIV = 5000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      length,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DUR_W+KEY_W-1:0] mem_rdata,
  output logic [KEY_W-1:0]       key_out,
  output logic                   key_valid,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             state_dbg
);

  state_t            state, state_n;
  logic              start_q;
  logic [ADDR_W-1:0] len_q, len_n, addr_n;
  logic [KEY_W-1:0]  key_n, rd_key;
  logic [DUR_W-1:0]  dur_cnt, dur_n, rd_dur;
  logic              kv_n, done_n;
  logic              start_rise, last_entry, entry_done, tick;

  assign rd_key     = `BEAT_KEY(mem_rdata, KEY_W);
  assign rd_dur     = `BEAT_DUR(mem_rdata, KEY_W, DUR_W);
  assign start_rise = start && !start_q;
  // len_q is at least 1 whenever an entry is being played, so this never underflows in use.
  assign last_entry = (mem_addr == len_q - 1'b1);
  assign busy       = (state == ST_ADDR) || (state == ST_WAIT) || (state == ST_PLAY);
  assign state_dbg  = state;

  // Divider is held reloaded outside PLAY so every entry starts a fresh tick period.
  playback_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state != ST_PLAY),
    .en     (state == ST_PLAY),
    .tick   (tick)
  );

  always_comb begin
    state_n    = state;
    addr_n     = mem_addr;
    key_n      = key_out;
    kv_n       = key_valid;
    done_n     = 1'b0;
    dur_n      = dur_cnt;
    len_n      = len_q;
    entry_done = 1'b0;
    if (!start) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      key_n   = '0;
      kv_n    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            len_n  = length;
            addr_n = '0;
            if (length == '0) begin
              state_n = ST_FINISH;
              done_n  = 1'b1;
            end else begin
              state_n = ST_ADDR;
            end
          end
        end
        ST_ADDR: state_n = ST_WAIT;
        ST_WAIT: begin
          // A zero-duration entry is skipped without ever raising key_valid.
          if (rd_dur != '0) begin
            state_n = ST_PLAY;
            key_n   = rd_key;
            kv_n    = 1'b1;
            dur_n   = rd_dur;
          end else begin
            entry_done = 1'b1;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (dur_cnt == DUR_W'(1)) begin
              kv_n       = 1'b0;
              entry_done = 1'b1;
            end else begin
              dur_n = dur_cnt - 1'b1;
            end
          end
        end
        ST_FINISH: state_n = ST_FINISH;
        default:   state_n = ST_IDLE;
      endcase
      if (entry_done) begin
        if (last_entry) begin
          done_n = 1'b1;
`ifdef PLAYBACK_LOOP_EN
          addr_n  = '0;
          state_n = ST_ADDR;
`else
          state_n = ST_FINISH;
`endif
        end else begin
          addr_n  = mem_addr + 1'b1;
          state_n = ST_ADDR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      // Treat start as already high so a level held across reset is not taken as a new edge.
      start_q   <= 1'b1;
      len_q     <= '0;
      mem_addr  <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      dur_cnt   <= '0;
    end else begin
      state     <= state_n;
      start_q   <= start;
      len_q     <= len_n;
      mem_addr  <= addr_n;
      key_out   <= key_n;
      key_valid <= kv_n;
      done      <= done_n;
      dur_cnt   <= dur_n;
    end
  end

endmodule

// File: tb/tb_beat_playback_sequencer.sv
`timescale 1ns/1ps
module tb_beat_playback_sequencer;
  import beat_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int KEY_W    = 7;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int BUDGET   = 400;

  // clock / reset block
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic                   start;
  logic [ADDR_W-1:0]      length;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DUR_W+KEY_W-1:0] mem_rdata;
  logic [KEY_W-1:0]       key_out;
  logic                   key_valid, busy, done;
  logic [2:0]             state_dbg;

  beat_playback_sequencer #(
    .ADDR_W(ADDR_W), .KEY_W(KEY_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .length(length),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .key_out(key_out),
    .key_valid(key_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // 1-cycle synchronous-read RAM model
  logic [ENTRY_W-1:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int x_seen = 0;
  int kv_cycles = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (key_valid) kv_cycles++;
    if (key_valid && key_out == 7'h58) x_seen++;
  end

  function automatic logic [ENTRY_W-1:0] ent(input int d, input logic [7:0] k);
    logic [7:0] dd;
    dd = d[7:0];
    return {dd, k[6:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Measures idle cycles before the next key_valid run and the length of that run.
  task automatic measure(output int gap, output int len, output logic [KEY_W-1:0] key, output bit steady);
    gap = 0; len = 0; steady = 1'b1;
    while (!key_valid && gap < BUDGET) begin gap++; step(1); end
    key = key_out;
    while (key_valid && len < BUDGET) begin
      if (key_out !== key) steady = 1'b0;
      len++;
      step(1);
    end
  endtask

  task automatic load_abc();
    mem[0] = ent(2, "A"); mem[1] = ent(1, "B"); mem[2] = ent(3, "C");
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; length = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    step(2);
    checks++;
    if ({mem_addr, key_out, key_valid, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got addr=%0d key=%0h kv=%0b busy=%0b done=%0b, want all 0", mem_addr, key_out, key_valid, busy, done);
    end
    resetn = 1'b1;
    step(2);
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_basic_playback();
    int gap, len, d0, kv0; logic [KEY_W-1:0] k; bit st;
    load_abc();
    d0 = done_cnt;
    length = 3; start = 1'b1;
    step(1);
    length = 0;  // must be ignored: length was captured when playback started
    measure(gap, len, k, st);
    checks++; if (gap !== 2) begin errors++; $display("FAIL basic_first_latency: got %0d want 2", gap); end
    checks++; if (k !== 7'h41 || !st) begin errors++; $display("FAIL basic_key_a: got %0h steady=%0b want 41", k, st); end
    checks++; if (len !== 8) begin errors++; $display("FAIL basic_len_a: got %0d want 8", len); end
    measure(gap, len, k, st);
    checks++; if (gap !== 2) begin errors++; $display("FAIL basic_gap_ab: got %0d want 2", gap); end
    checks++; if (k !== 7'h42 || !st) begin errors++; $display("FAIL basic_key_b: got %0h steady=%0b want 42", k, st); end
    checks++; if (len !== 4) begin errors++; $display("FAIL basic_len_b: got %0d want 4", len); end
    measure(gap, len, k, st);
    checks++; if (gap !== 2) begin errors++; $display("FAIL basic_gap_bc: got %0d want 2", gap); end
    checks++; if (k !== 7'h43 || !st) begin errors++; $display("FAIL basic_key_c: got %0h steady=%0b want 43", k, st); end
    checks++; if (len !== 12) begin errors++; $display("FAIL basic_len_c: got %0d want 12", len); end
    checks++;
    if (state_dbg !== S_FINISH || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_finish: got state=%0d done=%0b busy=%0b want state=%0d done=1 busy=0", state_dbg, done, busy, S_FINISH);
    end
    // start stays high in FINISH: no retrigger, outputs held
    kv0 = kv_cycles;
    step(6);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
    if (kv_cycles !== kv0 || state_dbg !== S_FINISH || mem_addr !== 8'd2 || key_out !== 7'h43) begin
      errors++; $display("FAIL finish_hold: got state=%0d addr=%0d key=%0h kv_cycles+%0d want state=%0d addr=2 key=43 +0", state_dbg, mem_addr, key_out, kv_cycles - kv0, S_FINISH);
    end
    start = 1'b0;
    step(1);
    checks++;
    if (state_dbg !== S_IDLE || mem_addr !== '0 || key_out !== '0) begin
      errors++; $display("FAIL finish_to_idle: got state=%0d addr=%0d key=%0h want %0d/0/0", state_dbg, mem_addr, key_out, S_IDLE);
    end
  endtask

  task automatic test_zero_length();
    int d0, kv0;
    d0 = done_cnt; kv0 = kv_cycles;
    length = 0; start = 1'b1;
    step(1);
    checks++;
    if (done !== 1'b1 || state_dbg !== S_FINISH) begin errors++; $display("FAIL zero_len_done: got done=%0b state=%0d want 1/%0d", done, state_dbg, S_FINISH); end
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse_width: got done=%0b want 0", done); end
    step(3);
    checks++;
    if (kv_cycles !== kv0 || mem_addr !== '0 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL zero_len_quiet: got kv_cycles+%0d addr=%0d dones=%0d want 0/0/1", kv_cycles - kv0, mem_addr, done_cnt - d0);
    end
    start = 1'b0;
    step(1);
  endtask

  task automatic test_zero_duration();
    int gap, len, x0; logic [KEY_W-1:0] k; bit st;
    mem[0] = ent(2, "A"); mem[1] = ent(0, "X"); mem[2] = ent(1, "B");
    x0 = x_seen;
    length = 3; start = 1'b1;
    step(1);
    measure(gap, len, k, st);
    checks++; if (k !== 7'h41 || len !== 8) begin errors++; $display("FAIL skip_first: got key=%0h len=%0d want 41/8", k, len); end
    measure(gap, len, k, st);
    checks++; if (gap !== 4) begin errors++; $display("FAIL skip_gap: got %0d want 4", gap); end
    checks++; if (k !== 7'h42 || len !== 4 || !st) begin errors++; $display("FAIL skip_next: got key=%0h len=%0d want 42/4", k, len); end
    checks++; if (x_seen !== x0) begin errors++; $display("FAIL skip_x_valid: got %0d cycles want 0", x_seen - x0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL skip_done: got %0b want 1", done); end
    start = 1'b0;
    step(1);
  endtask

  task automatic test_abort();
    int gap, len, n, d0; logic [KEY_W-1:0] k; bit st;
    load_abc();
    length = 3; start = 1'b1;
    step(1);
    measure(gap, len, k, st);
    n = 0;
    while (!key_valid && n < BUDGET) begin n++; step(1); end
    step(2);  // inside B's PLAY
    d0 = done_cnt;
    start = 1'b0;
    step(1);
    checks++;
    if (state_dbg !== S_IDLE || key_valid !== 1'b0 || mem_addr !== '0 || key_out !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got state=%0d kv=%0b addr=%0d key=%0h busy=%0b want %0d/0/0/0/0", state_dbg, key_valid, mem_addr, key_out, busy, S_IDLE);
    end
    step(3);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    start = 1'b1;
    step(1);
    measure(gap, len, k, st);
    checks++; if (k !== 7'h41 || len !== 8) begin errors++; $display("FAIL abort_restart: got key=%0h len=%0d want 41/8", k, len); end
    start = 1'b0;
    step(2);
  endtask

  task automatic test_async_reset();
    int gap, len, busy_n, kv0; logic [KEY_W-1:0] k; bit st;
    load_abc();
    length = 3; start = 1'b1;
    step(1);
    measure(gap, len, k, st);  // ends in ADDR of entry 1
    step(1);
    checks++;
    if (state_dbg !== S_WAIT || mem_addr !== 8'd1 || key_out !== 7'h41) begin
      errors++; $display("FAIL rst_setup: got state=%0d addr=%0d key=%0h want %0d/1/41", state_dbg, mem_addr, key_out, S_WAIT);
    end
    resetn = 1'b0;
    #2;
    checks++;
    if ({mem_addr, key_out, key_valid, busy, done} !== '0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rst_async: got addr=%0d key=%0h kv=%0b busy=%0b done=%0b state=%0d want all 0", mem_addr, key_out, key_valid, busy, done, state_dbg);
    end
    step(2);
    resetn = 1'b1;
    kv0 = kv_cycles; busy_n = 0;
    for (int i = 0; i < 10; i++) begin step(1); if (busy) busy_n++; end
    checks++;
    if (busy_n !== 0 || kv_cycles !== kv0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rst_quiet: got busy_cycles=%0d kv_cycles+%0d state=%0d want 0/0/%0d", busy_n, kv_cycles - kv0, state_dbg, S_IDLE);
    end
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    measure(gap, len, k, st);
    checks++; if (k !== 7'h41 || len !== 8 || gap !== 2) begin errors++; $display("FAIL rst_restart: got key=%0h len=%0d gap=%0d want 41/8/2", k, len, gap); end
    start = 1'b0;
    step(2);
  endtask

`ifdef PLAYBACK_LOOP_EN
  task automatic test_loop();
    int n, seen, d0;
    logic [ADDR_W-1:0] addrs [6];
    logic [ADDR_W-1:0] exp_a;
    mem[0] = ent(1, "P"); mem[1] = ent(1, "Q");
    d0 = done_cnt;
    length = 2; start = 1'b1;
    n = 0; seen = 0;
    while (seen < 6 && n < BUDGET) begin
      step(1); n++;
      if (state_dbg == S_WAIT) begin addrs[seen] = mem_addr; seen++; end
    end
    checks++; if (seen !== 6) begin errors++; $display("FAIL loop_progress: got %0d fetches want 6", seen); end
    for (int i = 0; i < 6; i++) begin
      exp_a = ADDR_W'(i % 2);
      checks++;
      if (addrs[i] !== exp_a) begin errors++; $display("FAIL loop_addr_%0d: got %0d want %0d", i, addrs[i], exp_a); end
    end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL loop_done_wraps: got %0d want 2", done_cnt - d0); end
    start = 1'b0;
    step(1);
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL loop_stop: got %0d want %0d", state_dbg, S_IDLE); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_playback();
    test_zero_length();
    test_zero_duration();
    test_abort();
    test_async_reset();
`ifdef PLAYBACK_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
